// File: rtl/universal_shift_register_pkg.sv
// Shared types for the universal shift register: mode encoding and counter width.
// Latency: n/a (types only). Backpressure: n/a.
// Optional rotate feature is selected by USR_ROTATE_EN in the interface and top.
package usr_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SHR  = 2'd1,
    SHL  = 2'd2,
    LOAD = 2'd3
  } mode_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Control/data bundle between a shift-register user (master) and the register (slave).
// Latency: n/a (wiring only). Backpressure: none, the register accepts a mode every cycle.
// With USR_ROTATE_EN defined the bundle also carries rot.
interface universal_shift_register_if #(
  parameter int WIDTH = 8
);
  localparam int CW = usr_pkg::cnt_w(WIDTH);

  usr_pkg::mode_t   mode;
  logic             sin;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;
  logic             done;

`ifdef USR_ROTATE_EN
  logic             rot;

  modport master (output mode, sin, d, rot, input q, count, done);
  modport slave  (input mode, sin, d, rot, output q, count, done);
`else
  modport master (output mode, sin, d, input q, count, done);
  modport slave  (input mode, sin, d, output q, count, done);
`endif

endinterface

// File: rtl/universal_shift_register_bit_cell.sv
// One register bit: 4:1 mode mux (self, upper, lower, load) into an async-reset flop.
// Latency: 1 cycle. Backpressure: none.
// Unknown modes fall through to hold.
module usr_bit_cell
  import usr_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  reset_n,
  input  mode_t mode,
  input  logic  q_hi,
  input  logic  q_lo,
  input  logic  d_bit,
  output logic  q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RST_BIT;
    end else begin
      case (mode)
        SHR:     q <= q_hi;
        SHL:     q <= q_lo;
        LOAD:    q <= d_bit;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit hold/shift-right/shift-left/load register with a frame counter pulsing done every WIDTH shifts.
// Latency: 1 cycle, all outputs registered. Backpressure: none, a mode is consumed every cycle.
// USR_ROTATE_EN adds rot: edge bits take the wrap bit instead of sin.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                       clk,
  input logic                       reset_n,
  universal_shift_register_if.slave bus
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] hi_vec;
  logic [WIDTH-1:0] lo_vec;
  logic             hi_in;
  logic             lo_in;
  logic [CW-1:0]    count_r;
  logic             done_r;

`ifdef USR_ROTATE_EN
  assign hi_in = bus.rot ? q_r[0]       : bus.sin;
  assign lo_in = bus.rot ? q_r[WIDTH-1] : bus.sin;
`else
  assign hi_in = bus.sin;
  assign lo_in = bus.sin;
`endif

  // Neighbour each bit sees: hi_vec feeds SHR, lo_vec feeds SHL.
  assign hi_vec = {hi_in, q_r[WIDTH-1:1]};
  assign lo_vec = {q_r[WIDTH-2:0], lo_in};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell #(
      .RST_BIT (RESET_VAL[i])
    ) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .mode    (bus.mode),
      .q_hi    (hi_vec[i]),
      .q_lo    (lo_vec[i]),
      .d_bit   (bus.d[i]),
      .q       (q_r[i])
    );
  end

  // Both shift directions share one frame; a load abandons the partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (bus.mode)
        SHR, SHL: begin
          if (count_r == LAST) begin
            count_r <= '0;
            done_r  <= 1'b1;
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        LOAD:    count_r <= '0;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.q     = q_r;
  assign bus.count = count_r;
  assign bus.done  = done_r;

  mode_known_a: assert property (@(posedge clk) disable iff (!reset_n) !$isunknown(bus.mode));

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised plus directed bench for universal_shift_register with a queue scoreboard
// and an arithmetic reference model; a second instance checks a non-zero reset value.
module tb_universal_shift_register;
  import usr_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [7:0] q;
    logic [2:0] count;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  exp_t exp_q[$];

  logic [7:0] m_q = 8'h00;
  int         m_shifts = 0;
  logic       m_done = 1'b0;

  universal_shift_register_if #(.WIDTH(W)) bus ();
  universal_shift_register_if #(.WIDTH(W)) bus2 ();

  universal_shift_register #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  universal_shift_register #(.WIDTH(W), .RESET_VAL(8'hA5)) dut_a5 (
    .clk(clk), .reset_n(reset_n), .bus(bus2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the register must hold after the next edge.
  task automatic step(input mode_t m, input logic s, input logic [7:0] dv, input logic r);
    logic fb;
    logic rr;
    exp_t e;
    @(negedge clk);
    bus.mode = m;
    bus.sin  = s;
    bus.d    = dv;
`ifdef USR_ROTATE_EN
    bus.rot = r;
    rr = r;
`else
    rr = r & 1'b0;
`endif
    m_done = 1'b0;
    case (m)
      SHR: begin
        fb = rr ? m_q[0] : s;
        m_q = (m_q >> 1) | (8'(fb) << 7);
        m_shifts++;
      end
      SHL: begin
        fb = rr ? m_q[7] : s;
        m_q = (m_q << 1) | 8'(fb);
        m_shifts++;
      end
      LOAD: begin
        m_q = dv;
        m_shifts = 0;
      end
      default: ;
    endcase
    if (m_shifts == W) begin
      m_shifts = 0;
      m_done = 1'b1;
    end
    e.q = m_q;
    e.count = 3'(m_shifts);
    e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_q", 64'(bus.q), 64'(e.q));
        chk("sb_count", 64'(bus.count), 64'(e.count));
        chk("sb_done", 64'(bus.done), 64'(e.done));
        if (bus.done === 1'b1) done_seen++;
      end
    end
  end

  initial begin : driver
    logic [7:0] pat;
    bus.mode = HOLD; bus.sin = 1'b0; bus.d = '0;
    bus2.mode = HOLD; bus2.sin = 1'b0; bus2.d = '0;
`ifdef USR_ROTATE_EN
    bus.rot = 1'b0;
    bus2.rot = 1'b0;
`endif
    #2 reset_n = 1'b0;
    #1;
    chk("rst_q", 64'(bus.q), 64'h00);
    chk("rst_count", 64'(bus.count), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_a5_q", 64'(bus2.q), 64'hA5);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    repeat (300) begin
      step(mode_t'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of a frame, away from any clock edge.
    step(LOAD, 1'b0, 8'h5A, 1'b0);
    repeat (3) step(SHL, 1'b1, 8'h00, 1'b0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_q", 64'(bus.q), 64'h00);
    chk("midrst_count", 64'(bus.count), 64'h0);
    chk("midrst_done", 64'(bus.done), 64'h0);
    m_q = 8'h00; m_shifts = 0; m_done = 1'b0;
    @(negedge clk);
    bus.mode = SHL; bus.sin = 1'b1;
    exp_q.push_back('{q: 8'h00, count: 3'd0, done: 1'b0});
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Serial in, parallel out.
    pat = 8'b1011_0010;
    step(LOAD, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(SHL, pat[7-i], 8'h00, 1'b0);
    settle();
    chk("sipo_q", 64'(bus.q), 64'hB2);
    chk("sipo_done", 64'(bus.done), 64'h1);

    // Parallel in, serial out.
    step(LOAD, 1'b0, 8'h81, 1'b0);
    for (int i = 0; i < 8; i++) step(SHR, 1'b0, 8'h00, 1'b0);
    settle();
    chk("piso_q", 64'(bus.q), 64'h00);

    // Partial frame abandoned by a load, then held.
    step(LOAD, 1'b0, 8'h00, 1'b0);
    repeat (5) step(SHL, 1'($urandom), 8'h00, 1'b0);
    step(LOAD, 1'b0, 8'h3C, 1'b0);
    settle();
    chk("abort_q", 64'(bus.q), 64'h3C);
    chk("abort_count", 64'(bus.count), 64'h0);
    repeat (3) step(HOLD, 1'($urandom), 8'($urandom), 1'b0);
    settle();
    chk("hold_q", 64'(bus.q), 64'h3C);

    // Direction change mid-frame, then two full frames back to back.
    step(LOAD, 1'b0, 8'h5A, 1'b0);
    repeat (4) step(SHR, 1'b1, 8'h00, 1'b0);
    repeat (4) step(SHL, 1'b0, 8'h00, 1'b0);
    settle();
    chk("mixed_done", 64'(bus.done), 64'h1);
    done_seen = 0;
    repeat (16) step(SHL, 1'($urandom), 8'h00, 1'b0);
    settle();
    chk("cont_pulses", 64'(done_seen), 64'd2);

`ifdef USR_ROTATE_EN
    step(LOAD, 1'b0, 8'h81, 1'b0);
    step(SHL, 1'b0, 8'h00, 1'b1);
    settle();
    chk("rot_shl_q", 64'(bus.q), 64'h03);
    step(LOAD, 1'b0, 8'h96, 1'b0);
    repeat (8) step(SHR, 1'b0, 8'h00, 1'b1);
    settle();
    chk("rot_shr_q", 64'(bus.q), 64'h96);
    chk("rot_shr_done", 64'(bus.done), 64'h1);
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("a5_hold_q", 64'(bus2.q), 64'hA5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
